// File: rtl/cpsr_pkg.sv
// cpsr_pkg: shared constants and types for the CPSR/SPSR flag unit.
// Condition codes, mode encodings, PSR bit positions, FSM states.
package cpsr_pkg;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int PSR_N = 31;
  localparam int PSR_Z = 30;
  localparam int PSR_C = 29;
  localparam int PSR_V = 28;
  localparam int PSR_I = 7;
  localparam int PSR_F = 6;
  localparam int PSR_T = 5;

  // Only NZCV and the control byte exist; everything else reads 0.
  localparam logic [31:0] PSR_MASK = 32'hF00000FF;
  localparam logic [31:0] CPSR_RST_CTRL = 32'h000000C0;
  localparam logic [31:0] CPSR_RESET = CPSR_RST_CTRL | {27'b0, MODE_SVC};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_EXC,
    ST_RET
  } psr_state_e;

endpackage

// File: rtl/cpsr_flag_unit_cond_eval.sv
// cond_eval: combinational ARM condition-field evaluation.
// Maps (NZCV, cond) to a pass bit; 4'b1111 always passes.
module cond_eval
  import cpsr_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b1;
    unique case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c & !z;
      CC_LS: pass = !c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpsr_flag_unit.sv
// cpsr_flag_unit: CPSR/SPSR storage, condition check, exception sequencing.
// `CPSR_FLAG_FWD_EN enables same-cycle NZCV bypass into condition evaluation.
module cpsr_flag_unit
  import cpsr_pkg::*;
#(
  parameter logic [4:0] RESET_MODE      = 5'b10011,
  parameter int         EXC_BUSY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  nzcv_in,
  input  logic        flag_we,
  input  logic        inst_valid,
  input  logic [3:0]  inst_cond,
  output logic        cond_valid,
  output logic        cond_pass,
  input  logic        msr_we,
  input  logic [1:0]  msr_mask,
  input  logic [31:0] msr_data,
  input  logic        exc_req,
  input  logic [4:0]  exc_mode,
  input  logic        eret,
  output logic        busy,
  output logic        cf_out,
  output logic        vf_out,
  output logic [31:0] cpsr,
  output logic [31:0] spsr
);

  localparam logic [31:0] RST_CPSR = CPSR_RST_CTRL | {27'b0, RESET_MODE};
  localparam logic [1:0]  BUSY_LAST = 2'(EXC_BUSY_CYCLES - 1);

  psr_state_e  state_q, state_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic [31:0] spsr_q, spsr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cv_q, cv_d;
  logic        cp_q, cp_d;
  logic [3:0]  eval_nzcv;
  logic [31:0] msr_sel;
  logic        pass;

  always_comb begin
    eval_nzcv = cpsr_q[31:28];
`ifdef CPSR_FLAG_FWD_EN
    // Bypass only when the flag write really lands this edge.
    if (flag_we && inst_valid && !exc_req && !eret && !msr_we)
      eval_nzcv = nzcv_in;
`endif
  end

  cond_eval u_cond (
    .nzcv (eval_nzcv),
    .cond (inst_cond),
    .pass (pass)
  );

  assign msr_sel = {{8{msr_mask[1]}}, 16'h0, {8{msr_mask[0]}}};

  always_comb begin
    state_d = state_q;
    cpsr_d  = cpsr_q;
    spsr_d  = spsr_q;
    cnt_d   = cnt_q;
    cv_d    = 1'b0;
    cp_d    = cp_q;
    unique case (state_q)
      ST_RUN: begin
        if (inst_valid) begin
          cv_d = 1'b1;
          cp_d = pass;
        end
        if (exc_req) begin
          spsr_d           = cpsr_q;
          cpsr_d[4:0]      = exc_mode;
          cpsr_d[PSR_I]    = 1'b1;
          cpsr_d[PSR_T]    = 1'b0;
          state_d          = ST_EXC;
          cnt_d            = BUSY_LAST;
        end else if (eret) begin
          cpsr_d  = spsr_q & PSR_MASK;
          state_d = ST_RET;
          cnt_d   = BUSY_LAST;
        end else if (msr_we) begin
          cpsr_d = ((cpsr_q & ~msr_sel) | (msr_data & msr_sel)) & PSR_MASK;
        end else if (flag_we) begin
          cpsr_d[31:28] = nzcv_in;
        end
      end
      ST_EXC, ST_RET: begin
        if (cnt_q == 2'd0) state_d = ST_RUN;
        else cnt_d = cnt_q - 2'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cpsr_q  <= RST_CPSR;
      spsr_q  <= 32'h0;
      cnt_q   <= 2'd0;
      cv_q    <= 1'b0;
      cp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cpsr_q  <= cpsr_d;
      spsr_q  <= spsr_d;
      cnt_q   <= cnt_d;
      cv_q    <= cv_d;
      cp_q    <= cp_d;
    end
  end

  assign busy       = (state_q != ST_RUN);
  assign cond_valid = cv_q;
  assign cond_pass  = cp_q;
  assign cf_out     = cpsr_q[PSR_C];
  assign vf_out     = cpsr_q[PSR_V];
  assign cpsr       = cpsr_q;
  assign spsr       = spsr_q;

endmodule
